// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the multi-port register file.
// Optional scoreboard is selected in regfile_mp with `define REGFILE_SCOREBOARD_EN.
package regfile_pkg;

  localparam int RF_REG_WIDTH = 64;
  localparam int RF_REG_COUNT = 32;
  localparam int RF_NUM_RD    = 2;
  localparam int RF_NUM_WR    = 2;

  // Upper bound on write ports handled by the priority helper.
  localparam int RF_MAX_WR    = 16;
  localparam int RF_IDX_W     = $clog2(RF_MAX_WR);

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  // Highest-index set bit wins; returns 0 when nothing matches (caller checks |hits).
  function automatic logic [RF_IDX_W-1:0] rf_prio_idx(input logic [RF_MAX_WR-1:0] hits);
    logic [RF_IDX_W-1:0] idx;
    idx = '0;
    for (int w = 0; w < RF_MAX_WR; w++)
      if (hits[w]) idx = RF_IDX_W'(w);
    return idx;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits for issue stalls.
// Instantiated by regfile_mp only when REGFILE_SCOREBOARD_EN is defined.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int REG_COUNT = RF_REG_COUNT,
  parameter int NUM_RD    = RF_NUM_RD,
  parameter int NUM_WR    = RF_NUM_WR,
  parameter int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ready,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
  input  logic                           iss_en,
  input  logic [ADDR_W-1:0]              iss_addr,
  input  logic                           flush,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
  input  logic [NUM_RD-1:0]              rd_fwd,
  output logic [NUM_RD-1:0]              rd_busy
);

  logic [REG_COUNT-1:0] busy, busy_d;

  // Next busy vector: writebacks clear, issue sets (set beats clear), flush beats all.
  always_comb begin
    busy_d = busy;
    if (ready) begin
      for (int w = 0; w < NUM_WR; w++)
        if (wr_en[w] && wr_addr[w] != '0) busy_d[wr_addr[w]] = 1'b0;
      if (iss_en && iss_addr != '0) busy_d[iss_addr] = 1'b1;
      if (flush) busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // Busy register, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_d;
  end

  // A value being forwarded this cycle is never reported busy.
  always_comb begin
    rd_busy = '0;
    for (int r = 0; r < NUM_RD; r++)
      rd_busy[r] = ready && busy[rd_addr[r]] && !rd_fwd[r];
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NUM_RD-read / NUM_WR-write register file with same-cycle
// forwarding and a post-reset clear sweep (storage itself has no reset).
// Define REGFILE_SCOREBOARD_EN to build the busy scoreboard; otherwise
// iss_en/iss_addr/flush are ignored and rd_busy is tied low.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int REG_WIDTH = RF_REG_WIDTH,
  parameter int REG_COUNT = RF_REG_COUNT,
  parameter int NUM_RD    = RF_NUM_RD,
  parameter int NUM_WR    = RF_NUM_WR,
  parameter int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             ready,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]    wr_addr,
  input  logic [NUM_WR-1:0][REG_WIDTH-1:0] wr_data,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]    rd_addr,
  output logic [NUM_RD-1:0][REG_WIDTH-1:0] rd_data,
  input  logic                             iss_en,
  input  logic [ADDR_W-1:0]                iss_addr,
  input  logic                             flush,
  output logic [NUM_RD-1:0]                rd_busy
);

  localparam int WR_IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  rf_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     clr_idx, clr_idx_d;
  logic                  clearing;
  logic [NUM_WR-1:0]     wr_en_g;
  logic [NUM_RD-1:0]     rd_fwd;
  logic [REG_WIDTH-1:0]  regs [REG_COUNT];

  assign ready   = (state_q == RF_READY);
  assign wr_en_g = wr_en & {NUM_WR{ready}};

  // Sweep state and index; reset restarts the sweep from entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_CLEAR;
      clr_idx <= '0;
    end else begin
      state_q <= state_d;
      clr_idx <= clr_idx_d;
    end
  end

  // Sweep next-state: zero one entry per cycle, finish after the last entry.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx;
    clearing  = 1'b0;
    case (state_q)
      RF_CLEAR: begin
        clearing  = 1'b1;
        clr_idx_d = clr_idx + 1'b1;
        if (clr_idx == ADDR_W'(REG_COUNT - 1)) state_d = RF_READY;
      end
      RF_READY: state_d = RF_READY;
      default:  state_d = RF_CLEAR;
    endcase
  end

  // Storage: sweep zeroing, else port writes in index order so the highest port lands last.
  always_ff @(posedge clk) begin
    if (clearing) begin
      regs[clr_idx] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (wr_en_g[w] && wr_addr[w] != '0) regs[wr_addr[w]] <= wr_data[w];
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [NUM_WR-1:0]    hit;
    logic [RF_MAX_WR-1:0] hit_x;
    logic [WR_IDX_W-1:0]  sel;

    // Read mux: x0 and not-ready read zero, then forwarding, then storage.
    always_comb begin
      hit = '0;
      for (int w = 0; w < NUM_WR; w++)
        hit[w] = wr_en_g[w] && (wr_addr[w] == rd_addr[r]);
      hit_x = '0;
      hit_x[NUM_WR-1:0] = hit;
      sel = WR_IDX_W'(rf_prio_idx(hit_x));
      rd_fwd[r] = |hit;
      if (!ready || rd_addr[r] == '0) rd_data[r] = '0;
      else if (|hit)                  rd_data[r] = wr_data[sel];
      else                            rd_data[r] = regs[rd_addr[r]];
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  regfile_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .NUM_RD    (NUM_RD),
    .NUM_WR    (NUM_WR),
    .ADDR_W    (ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .wr_en    (wr_en_g),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .rd_addr  (rd_addr),
    .rd_fwd   (rd_fwd),
    .rd_busy  (rd_busy)
  );
`else
  logic sb_unused;
  assign sb_unused = ^{iss_en, iss_addr, flush, rd_fwd};
  assign rd_busy   = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed, table-driven bench for regfile_mp (defaults 64x32, 2R/2W).
// Scoreboard checks follow REGFILE_SCOREBOARD_EN.
module tb_regfile_mp;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ready;
  logic [1:0]           wr_en;
  logic [1:0][4:0]      wr_addr;
  logic [1:0][63:0]     wr_data;
  logic [1:0][4:0]      rd_addr;
  logic [1:0][63:0]     rd_data;
  logic                 iss_en;
  logic [4:0]           iss_addr;
  logic                 flush;
  logic [1:0]           rd_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .rd_busy  (rd_busy)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [63:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic [63:0] e0, e1;
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Counts rising edges until ready, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    tv[0] = '{2'b11, 5'd7,  5'd7,  64'hAAAA, 64'h5555, 5'd7,  5'd5,  64'h5555, 64'h0};
    tv[1] = '{2'b00, 5'd0,  5'd0,  64'h0,    64'h0,    5'd7,  5'd0,  64'h5555, 64'h0};
    tv[2] = '{2'b01, 5'd0,  5'd0,  64'hFFFF, 64'h0,    5'd0,  5'd7,  64'h0,    64'h5555};
    tv[3] = '{2'b11, 5'd0,  5'd0,  64'hFFFF, 64'hEEEE, 5'd0,  5'd1,  64'h0,    64'h0};
    tv[4] = '{2'b11, 5'd10, 5'd9,  64'hABCD, 64'h1234, 5'd10, 5'd9,  64'hABCD, 64'h1234};
    tv[5] = '{2'b01, 5'd9,  5'd9,  64'h1111, 64'h9999, 5'd9,  5'd10, 64'h1111, 64'hABCD};
    tv[6] = '{2'b00, 5'd0,  5'd0,  64'h0,    64'h0,    5'd9,  5'd31, 64'h1111, 64'h0};
    tv[7] = '{2'b11, 5'd1,  5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_0000_0001,
              5'd31, 5'd1,  64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
    tv[8] = '{2'b00, 5'd0,  5'd0,  64'h0,    64'h0,    5'd31, 5'd1,
              64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
    tv[9] = '{2'b01, 5'd2,  5'd5,  64'h22,   64'h99,   5'd5,  5'd2,  64'h0,    64'h22};

    // Reset state
    rst_n = 1'b0; idle(); rd_addr = {5'd5, 5'd7};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'h0);
    chk("rst_rd0", rd_data[0], 64'h0);
    chk("rst_busy", 64'(rd_busy), 64'h0);

    // Sweep with writes/issue attempts that must be ignored
    rst_n = 1'b1;
    wr_en = 2'b01; wr_addr[0] = 5'd6; wr_data[0] = 64'h77;
    iss_en = 1'b1; iss_addr = 5'd6; rd_addr = {5'd5, 5'd6};
    #1;
    chk("sweep_rd_zero", rd_data[0], 64'h0);
    wait_ready(n);
    idle();
    chk("sweep_cycles", 64'(n), 64'd32);
    @(negedge clk);
    chk("ready_up", 64'(ready), 64'h1);
    chk("ign_write_x6", rd_data[0], 64'h0);
    chk("read_x5", rd_data[1], 64'h0);
    chk("ign_iss_x6", 64'(rd_busy), 64'h0);

    // Table-driven write/forward/read vectors, one per cycle
    for (int i = 0; i < 10; i++) begin
      step();
      wr_en = tv[i].we; wr_addr = {tv[i].wa1, tv[i].wa0};
      wr_data = {tv[i].wd1, tv[i].wd0}; rd_addr = {tv[i].ra1, tv[i].ra0};
      @(negedge clk);
      chk($sformatf("vec%0d_rd0", i), rd_data[0], tv[i].e0);
      chk($sformatf("vec%0d_rd1", i), rd_data[1], tv[i].e1);
    end
    step(); idle();

`ifdef REGFILE_SCOREBOARD_EN
    // Issue x3, visible next cycle
    iss_en = 1'b1; iss_addr = 5'd3; rd_addr = {5'd4, 5'd3};
    @(negedge clk);
    chk("sb_iss_same", 64'(rd_busy), 64'h0);
    step(); idle();
    @(negedge clk);
    chk("sb_iss_next", 64'(rd_busy), 64'h1);
    // Writeback and re-issue of x3 together: set wins
    step();
    wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 64'h33;
    iss_en = 1'b1; iss_addr = 5'd3;
    @(negedge clk);
    chk("sb_fwd_notbusy", 64'(rd_busy), 64'h0);
    step(); idle();
    @(negedge clk);
    chk("sb_set_wins", 64'(rd_busy), 64'h1);
    chk("sb_wb_data", rd_data[0], 64'h33);
    // Flush overrides a concurrent issue of x4
    step();
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd4;
    @(negedge clk);
    chk("sb_flush_same", 64'(rd_busy), 64'h1);
    step(); idle();
    @(negedge clk);
    chk("sb_flush", 64'(rd_busy), 64'h0);
`else
    iss_en = 1'b1; iss_addr = 5'd3; rd_addr = {5'd4, 5'd3};
    step(); idle();
    @(negedge clk);
    chk("nosb_busy_low", 64'(rd_busy), 64'h0);
`endif

    // Write x4, then reset mid-sweep: contents cleared
    step();
    wr_en = 2'b10; wr_addr[1] = 5'd4; wr_data[1] = 64'h4444; rd_addr = {5'd7, 5'd4};
    step(); idle();
    @(negedge clk);
    chk("x4_written", rd_data[0], 64'h4444);
    step();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    repeat (10) step();
    chk("mid_sweep_notready", 64'(ready), 64'h0);
    rst_n = 1'b0; #2; rst_n = 1'b1;
    wait_ready(n);
    chk("resweep_cycles", 64'(n), 64'd32);
    @(negedge clk);
    chk("x4_cleared", rd_data[0], 64'h0);
    chk("x7_cleared", rd_data[1], 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
